// File: rtl/tolower_stream_if.sv
// Byte-stream channel for tolower_stream: upstream push side, downstream pop side and status.
// conv_count is only present when TOLOWER_COUNT_EN is defined.
interface tolower_stream_if #(
  parameter int CNT_W = 16
);
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       mode_en;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
`ifdef TOLOWER_COUNT_EN
  logic [CNT_W-1:0] conv_count;

  modport master (
    output in_data, in_valid, mode_en, out_ready,
    input  in_ready, out_data, out_valid, busy, conv_count
  );

  modport slave (
    input  in_data, in_valid, mode_en, out_ready,
    output in_ready, out_data, out_valid, busy, conv_count
  );
`else
  modport master (
    output in_data, in_valid, mode_en, out_ready,
    input  in_ready, out_data, out_valid, busy
  );

  modport slave (
    input  in_data, in_valid, mode_en, out_ready,
    output in_ready, out_data, out_valid, busy
  );
`endif
endinterface

// File: rtl/tolower_stream.sv
// Streaming ASCII upper-to-lower converter with a DEPTH-entry output buffer.
// Define TOLOWER_COUNT_EN to build in the saturating conversion counter (conv_count).
module tolower_stream #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input logic            clk,
  input logic            rst_n,
  tolower_stream_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } occ_state_t;

  occ_state_t       state;
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occupancy;

  logic       accept;
  logic       pop;
  logic       convert;
  logic [7:0] wr_byte;

  assign bus.in_ready  = rst_n && (state != FULL);
  assign bus.out_valid = (state != EMPTY);
  assign bus.busy      = bus.out_valid;
  assign bus.out_data  = mem[rd_ptr];

  assign accept  = bus.in_valid && bus.in_ready;
  assign pop     = bus.out_valid && bus.out_ready;
  // Case is fixed at write time, so later mode_en changes never touch buffered bytes.
  assign convert = bus.mode_en && (bus.in_data >= 8'h41) && (bus.in_data <= 8'h5A);
  assign wr_byte = convert ? (bus.in_data | 8'h20) : bus.in_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      state     <= EMPTY;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else begin
      if (accept) begin
        mem[wr_ptr] <= wr_byte;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      // State mirrors the occupancy count so the handshake outputs decode from one register.
      case ({accept, pop})
        2'b10: begin
          occupancy <= occupancy + OCC_W'(1);
          state     <= (occupancy == OCC_W'(DEPTH - 1)) ? FULL : PARTIAL;
        end
        2'b01: begin
          occupancy <= occupancy - OCC_W'(1);
          state     <= (occupancy == OCC_W'(1)) ? EMPTY : PARTIAL;
        end
        default: begin
          occupancy <= occupancy;
          state     <= state;
        end
      endcase
    end
  end

`ifdef TOLOWER_COUNT_EN
  logic [CNT_W-1:0] conv_count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      conv_count_q <= '0;
    end else if (accept && convert && (conv_count_q != {CNT_W{1'b1}})) begin
      conv_count_q <= conv_count_q + CNT_W'(1);
    end
  end

  assign bus.conv_count = conv_count_q;
`endif

endmodule

// File: doc/tolower_stream.md
# tolower_stream

Streaming ASCII upper-to-lower case converter. It is the inverse of the team's combinational toupper stage: it restores letter case on a byte stream by adding 32 (setting bit 5) to 'A'..'Z'. It sits on a valid/ready byte channel and provides a small output buffer so upstream and downstream can stall independently. An optional saturating counter reports how many bytes were actually converted.

## Interface
Parameters:
- DEPTH, 2, output buffer entries; power of two, at least 2.
- CNT_W, 16, conversion counter width; only used when the counter is compiled in.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_data  input  8  input byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a byte this cycle.
- mode_en  input  1  1 = convert, 0 = pass-through; sampled per accepted byte.
- out_data  output  8  head-of-buffer byte.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data this cycle.
- busy  output  1  buffer is non-empty.
- conv_count  output  CNT_W  number of converted bytes (present only with TOLOWER_COUNT_EN).

## Operation
- Accept: a byte is accepted when in_valid && in_ready. Pop: a byte leaves when out_valid && out_ready.
- Conversion is applied when the byte is written into the buffer:
  - If mode_en = 1 and 0x41 <= in_data <= 0x5A, the stored byte is in_data | 0x20.
  - Otherwise the byte is stored unchanged. This includes 0x40, 0x5B, lowercase, and every byte with bit 7 set.
- Buffer:
  - DEPTH-entry circular store with registered write and read pointers of width log2(DEPTH), wrapping modulo DEPTH.
  - A registered occupancy counter runs 0..DEPTH.
- Occupancy states, decoded from the occupancy counter:
  - EMPTY (0) -> PARTIAL on an accept.
  - PARTIAL -> FULL when an accept raises occupancy to DEPTH.
  - PARTIAL -> EMPTY when a pop lowers occupancy to 0.
  - FULL -> PARTIAL on a pop.
  - A simultaneous accept and pop leaves occupancy unchanged.
- in_ready = rst_n && (occupancy != DEPTH). It depends only on registered state; there is no combinational path from out_ready.
- While FULL, in_ready stays 0 even if out_ready = 1 in the same cycle.
- out_valid = (occupancy != 0). out_data = entry at the read pointer. busy = out_valid.
- While out_valid = 1 and out_ready = 0, out_data holds stable.
- in_data is ignored whenever in_valid = 0 or in_ready = 0.

## Timing
- Latency: a byte accepted on edge N is presented on out_data/out_valid immediately after edge N when the buffer was empty, i.e. one cycle of latency.
- Throughput: one byte per cycle sustained when out_ready is held at 1.
- Reset, applied at an edge with rst_n = 0:
  - Pointers = 0, occupancy = 0, out_valid = 0, busy = 0, conv_count = 0.
  - out_data = 0x00, because the buffer contents are cleared.
  - in_ready = 0 while rst_n = 0, and 1 on the first cycle after release.
- Reset mid-operation discards all buffered bytes; no partial output is produced.
- mode_en is taken in the same cycle as the accepted byte. Changing it never alters bytes already buffered.

## Configuration
- TOLOWER_COUNT_EN defined:
  - conv_count port exists.
  - It increments by 1 on each accepted byte that is actually converted.
  - It saturates at 2^CNT_W - 1.
  - It is cleared only by reset.
- TOLOWER_COUNT_EN undefined: conv_count port and counter logic are absent; all other behaviour is identical.

## Test plan
- Reset, then accept 0x41, 0x5A, 0x40, 0x5B, 0x61 with mode_en = 1 and out_ready = 1 -> out sequence 0x61, 0x7A, 0x40, 0x5B, 0x61, one cycle each; conv_count = 2.
- Same bytes with mode_en = 0 -> output identical to input; conv_count unchanged. Also send 0xC1 with mode_en = 1 -> 0xC1 out unchanged.
- out_ready = 0, push 0x48, 0x49 (DEPTH = 2) -> in_ready drops to 0 after the second accept. Then assert in_valid and out_ready together -> first cycle pops 0x68 with no accept; next cycle accepts.
- Random in_valid/out_ready over 1000 random bytes -> output stream equals the reference-model conversion in order; no loss or duplication; out_data stable while stalled.
- Assert rst_n = 0 with 2 bytes buffered -> next cycle out_valid = 0, busy = 0, conv_count = 0; after release, the first accepted byte appears with 1-cycle latency.
- With CNT_W = 2, convert 5 uppercase bytes -> conv_count reaches 3 and holds at 3.
